// File: rtl/sqrwav_meas.sv
// sqrwav_meas: measures HIGH and LOW phase durations of an asynchronous square wave in TICK_CYCLES units
// Ports: clk, rst (synchronous, active-high); wave_in asynchronous square wave;
//    m_out/n_out last HIGH/LOW duration in units; valid one-cycle update strobe;
//    err set with valid when either duration is 0; stuck wave held at one level for 16+ units
module sqrwav_meas #(
   parameter int TICK_CYCLES = 10
) (
   input  logic       clk,
   input  logic       rst,
   input  logic       wave_in,
   output logic [3:0] m_out,
   output logic [3:0] n_out,
   output logic       valid,
   output logic       err,
   output logic       stuck
);
   localparam int PW = $clog2(TICK_CYCLES);
   typedef enum logic [1:0] {IDLE, HIGH, LOW} state_t;
   state_t        state_q;
   logic          sync1_q, sync2_q, prev_q;
   logic [PW-1:0] pre_q, pre_d;
   logic [4:0]    units_q, units_d;
   logic [3:0]    m_lat_q, m_q, n_q;
   logic          valid_q, err_q, stuck_q;
   logic          rise, fall, wrap, over;
   always_comb begin
      rise = sync2_q & ~prev_q;
      fall = ~sync2_q & prev_q;
      wrap = pre_q == PW'(TICK_CYCLES - 1);
      pre_d = wrap ? '0 : pre_q + 1'b1;
      // counters clear on the edge cycle itself, so units_d counts the current cycle too and
      // equals floor(L / TICK_CYCLES) in the cycle the closing edge is detected
      units_d = units_q + {4'd0, wrap};
      over = (state_q != IDLE) && (units_d == 5'd16);
   end
   always_ff @(posedge clk) begin
      if (rst) begin
         // all-ones sync flops: a wave already high at release needs a real low before a rise counts
         {sync1_q, sync2_q, prev_q} <= 3'b111;
         state_q <= IDLE;
         pre_q <= '0;
         units_q <= '0;
         m_lat_q <= '0;
         m_q <= '0;
         n_q <= '0;
         valid_q <= 1'b0;
         err_q <= 1'b0;
         stuck_q <= 1'b0;
      end else begin
         {sync1_q, sync2_q, prev_q} <= {wave_in, sync1_q, sync2_q};
         valid_q <= 1'b0;
         {pre_q, units_q} <= (state_q == IDLE || rise || fall || over) ? '0 : {pre_d, units_d};
         if (over) begin
            // a 16-unit phase wins over any edge in the same cycle; the partial measurement is dropped
            state_q <= IDLE;
            stuck_q <= 1'b1;
         end else begin
            case (state_q)
               IDLE: state_q <= rise ? HIGH : IDLE;
               HIGH: begin
                  if (fall) begin
                     m_lat_q <= units_d[3:0];
                     state_q <= LOW;
                  end
               end
               LOW: begin
                  if (rise) begin
                     m_q <= m_lat_q;
                     n_q <= units_d[3:0];
                     err_q <= (m_lat_q == 4'd0) || (units_d[3:0] == 4'd0);
                     valid_q <= 1'b1;
                     stuck_q <= 1'b0;
                     state_q <= HIGH;
                  end
               end
               default: state_q <= IDLE;
            endcase
         end
      end
   end
   assign m_out = m_q;
   assign n_out = n_q;
   assign valid = valid_q;
   assign err = err_q;
   assign stuck = stuck_q;
endmodule

// File: tb/tb_sqrwav_meas.sv
// tb_sqrwav_meas: self-checking bench for sqrwav_meas against a phase-list reference model
module tb_sqrwav_meas;
   localparam int T = 4;
   logic       clk = 1'b0;
   logic       rst = 1'b1;
   logic       wave_in = 1'b0;
   logic [3:0] m_out, n_out;
   logic       valid, err, stuck;
   int         checks = 0;
   int         failures = 0;
   int         cyc = 0;
   int         ph_len[$];
   bit         ph_lvl[$];
   int         exp_m[$], exp_n[$], exp_cyc[$];
   bit         exp_err[$];
   bit         exp_stuck;
   int         obs_m[$], obs_n[$], obs_cyc[$];
   bit         obs_err[$], obs_stuck[$];

   sqrwav_meas #(.TICK_CYCLES(T)) dut (
      .clk(clk), .rst(rst), .wave_in(wave_in),
      .m_out(m_out), .n_out(n_out), .valid(valid), .err(err), .stuck(stuck)
   );

   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;
   always @(negedge clk) begin
      if (!rst && valid) begin
         obs_m.push_back(int'(m_out));
         obs_n.push_back(int'(n_out));
         obs_err.push_back(err);
         obs_stuck.push_back(stuck);
         obs_cyc.push_back(cyc);
      end
   end

   task automatic apply_reset(input int n);
      rst = 1'b1;
      repeat (n) @(negedge clk);
      rst = 1'b0;
      ph_len.delete(); ph_lvl.delete();
      exp_m.delete(); exp_n.delete(); exp_err.delete(); exp_cyc.delete();
      obs_m.delete(); obs_n.delete(); obs_err.delete(); obs_stuck.delete(); obs_cyc.delete();
      exp_stuck = 1'b0;
   endtask

   // Model: a report appears at every rising edge that closes a high phase (not the first phase
   // after reset) and the following low phase, both shorter than 16 units; values are floor(L/T).
   task automatic drive(input logic lvl, input int n);
      int i;
      if (ph_lvl.size() == 0 || ph_lvl[ph_lvl.size()-1] != lvl) begin
         ph_lvl.push_back(lvl);
         ph_len.push_back(0);
         i = ph_lvl.size() - 1;
         if (lvl && i >= 3 && ph_len[i-2] < 16*T && ph_len[i-1] < 16*T) begin
            exp_m.push_back(ph_len[i-2] / T);
            exp_n.push_back(ph_len[i-1] / T);
            exp_err.push_back((ph_len[i-2] / T == 0) || (ph_len[i-1] / T == 0));
            exp_cyc.push_back(cyc + 3);
            exp_stuck = 1'b0;
         end
      end
      wave_in = lvl;
      ph_len[ph_len.size()-1] += n;
      if (ph_len[ph_len.size()-1] >= 16*T) exp_stuck = 1'b1;
      repeat (n) @(negedge clk);
   endtask

   task automatic test_reset;
      apply_reset(3);
      checks++;
      if ({m_out, n_out, valid, err, stuck} !== 11'd0) begin
         failures++;
         $display("FAIL reset_outputs: got m=%0d n=%0d valid=%0d err=%0d stuck=%0d, expected all 0", m_out, n_out, valid, err, stuck);
      end
   endtask

   task automatic test_periodic;
      apply_reset(2);
      drive(0, 4);
      repeat (4) begin
         drive(1, 12);
         drive(0, 20);
      end
      drive(1, 4);
      #1;
      checks++;
      if (obs_m.size() !== exp_m.size()) begin
         failures++;
         $display("FAIL periodic_count: got %0d valid pulses, expected %0d", obs_m.size(), exp_m.size());
      end
      for (int i = 0; i < exp_m.size() && i < obs_m.size(); i++) begin
         checks++;
         if (obs_m[i] !== exp_m[i] || obs_n[i] !== exp_n[i] || obs_err[i] !== exp_err[i] || obs_stuck[i] !== 1'b0 || obs_cyc[i] !== exp_cyc[i]) begin
            failures++;
            $display("FAIL periodic_valid%0d: got m=%0d n=%0d err=%0d stuck=%0d cyc=%0d, expected m=%0d n=%0d err=%0d stuck=0 cyc=%0d",
                     i, obs_m[i], obs_n[i], obs_err[i], obs_stuck[i], obs_cyc[i], exp_m[i], exp_n[i], exp_err[i], exp_cyc[i]);
         end
      end
   endtask

   task automatic test_floor_err;
      apply_reset(2);
      drive(0, 4);
      drive(1, 14);
      drive(0, 7);
      drive(1, 2);
      drive(0, 8);
      drive(1, 14);
      drive(0, 7);
      #1;
      checks++;
      if (err !== exp_err[exp_err.size()-1]) begin
         failures++;
         $display("FAIL err_hold_set: got err=%0d, expected %0d", err, exp_err[exp_err.size()-1]);
      end
      drive(1, 5);
      drive(0, 6);
      #1;
      checks++;
      if (err !== exp_err[exp_err.size()-1]) begin
         failures++;
         $display("FAIL err_hold_clear: got err=%0d, expected %0d", err, exp_err[exp_err.size()-1]);
      end
      checks++;
      if (obs_m.size() !== exp_m.size()) begin
         failures++;
         $display("FAIL floor_count: got %0d valid pulses, expected %0d", obs_m.size(), exp_m.size());
      end
      for (int i = 0; i < exp_m.size() && i < obs_m.size(); i++) begin
         checks++;
         if (obs_m[i] !== exp_m[i] || obs_n[i] !== exp_n[i] || obs_err[i] !== exp_err[i] || obs_cyc[i] !== exp_cyc[i]) begin
            failures++;
            $display("FAIL floor_valid%0d: got m=%0d n=%0d err=%0d cyc=%0d, expected m=%0d n=%0d err=%0d cyc=%0d",
                     i, obs_m[i], obs_n[i], obs_err[i], obs_cyc[i], exp_m[i], exp_n[i], exp_err[i], exp_cyc[i]);
         end
      end
   endtask

   task automatic test_stuck;
      apply_reset(2);
      drive(0, 4);
      drive(1, 60);
      drive(0, 60);
      drive(1, 60);
      drive(0, 60);
      drive(1, 80);
      #1;
      checks++;
      if (stuck !== exp_stuck || int'(m_out) !== exp_m[exp_m.size()-1] || int'(n_out) !== exp_n[exp_n.size()-1]) begin
         failures++;
         $display("FAIL stuck_high: got stuck=%0d m=%0d n=%0d, expected stuck=%0d m=%0d n=%0d",
                  stuck, m_out, n_out, exp_stuck, exp_m[exp_m.size()-1], exp_n[exp_n.size()-1]);
      end
      drive(0, 20);
      drive(1, 12);
      drive(0, 20);
      #1;
      checks++;
      if (stuck !== exp_stuck) begin
         failures++;
         $display("FAIL stuck_hold: got stuck=%0d, expected %0d", stuck, exp_stuck);
      end
      drive(1, 63);
      drive(0, 40);
      drive(1, 64);
      drive(0, 10);
      #1;
      checks++;
      if (stuck !== exp_stuck) begin
         failures++;
         $display("FAIL stuck_boundary64: got stuck=%0d, expected %0d", stuck, exp_stuck);
      end
      drive(1, 5);
      #1;
      checks++;
      if (obs_m.size() !== exp_m.size()) begin
         failures++;
         $display("FAIL stuck_count: got %0d valid pulses, expected %0d", obs_m.size(), exp_m.size());
      end
      for (int i = 0; i < exp_m.size() && i < obs_m.size(); i++) begin
         checks++;
         if (obs_m[i] !== exp_m[i] || obs_n[i] !== exp_n[i] || obs_err[i] !== exp_err[i] || obs_stuck[i] !== 1'b0 || obs_cyc[i] !== exp_cyc[i]) begin
            failures++;
            $display("FAIL stuck_valid%0d: got m=%0d n=%0d err=%0d stuck=%0d cyc=%0d, expected m=%0d n=%0d err=%0d stuck=0 cyc=%0d",
                     i, obs_m[i], obs_n[i], obs_err[i], obs_stuck[i], obs_cyc[i], exp_m[i], exp_n[i], exp_err[i], exp_cyc[i]);
         end
      end
   endtask

   task automatic test_reset_high;
      wave_in = 1'b1;
      apply_reset(3);
      drive(1, 30);
      drive(0, 20);
      drive(1, 12);
      #1;
      checks++;
      if (obs_m.size() !== 0) begin
         failures++;
         $display("FAIL reset_high_partial: got %0d valid pulses, expected 0", obs_m.size());
      end
      drive(0, 20);
      drive(1, 5);
      #1;
      checks++;
      if (obs_m.size() !== exp_m.size()) begin
         failures++;
         $display("FAIL reset_high_count: got %0d valid pulses, expected %0d", obs_m.size(), exp_m.size());
      end
      for (int i = 0; i < exp_m.size() && i < obs_m.size(); i++) begin
         checks++;
         if (obs_m[i] !== exp_m[i] || obs_n[i] !== exp_n[i] || obs_err[i] !== exp_err[i] || obs_cyc[i] !== exp_cyc[i]) begin
            failures++;
            $display("FAIL reset_high_valid%0d: got m=%0d n=%0d err=%0d cyc=%0d, expected m=%0d n=%0d err=%0d cyc=%0d",
                     i, obs_m[i], obs_n[i], obs_err[i], obs_cyc[i], exp_m[i], exp_n[i], exp_err[i], exp_cyc[i]);
         end
      end
   endtask

   task automatic test_reset_mid;
      wave_in = 1'b0;
      apply_reset(2);
      drive(0, 5);
      repeat (2) begin
         drive(1, 12);
         drive(0, 20);
      end
      drive(1, 12);
      drive(0, 8);
      #1;
      checks++;
      if (int'(m_out) !== exp_m[exp_m.size()-1] || int'(n_out) !== exp_n[exp_n.size()-1] || obs_m.size() !== exp_m.size()) begin
         failures++;
         $display("FAIL pre_reset_values: got m=%0d n=%0d pulses=%0d, expected m=%0d n=%0d pulses=%0d",
                  m_out, n_out, obs_m.size(), exp_m[exp_m.size()-1], exp_n[exp_n.size()-1], exp_m.size());
      end
      apply_reset(1);
      checks++;
      if ({m_out, n_out, valid, err, stuck} !== 11'd0) begin
         failures++;
         $display("FAIL mid_reset_outputs: got m=%0d n=%0d valid=%0d err=%0d stuck=%0d, expected all 0", m_out, n_out, valid, err, stuck);
      end
      drive(0, 12);
      drive(1, 12);
      drive(0, 20);
      #1;
      checks++;
      if (obs_m.size() !== 0) begin
         failures++;
         $display("FAIL mid_reset_early_valid: got %0d valid pulses, expected 0", obs_m.size());
      end
      drive(1, 12);
      drive(0, 20);
      drive(1, 4);
      #1;
      checks++;
      if (obs_m.size() !== exp_m.size()) begin
         failures++;
         $display("FAIL mid_reset_count: got %0d valid pulses, expected %0d", obs_m.size(), exp_m.size());
      end
      for (int i = 0; i < exp_m.size() && i < obs_m.size(); i++) begin
         checks++;
         if (obs_m[i] !== exp_m[i] || obs_n[i] !== exp_n[i] || obs_err[i] !== exp_err[i] || obs_cyc[i] !== exp_cyc[i]) begin
            failures++;
            $display("FAIL mid_reset_valid%0d: got m=%0d n=%0d err=%0d cyc=%0d, expected m=%0d n=%0d err=%0d cyc=%0d",
                     i, obs_m[i], obs_n[i], obs_err[i], obs_cyc[i], exp_m[i], exp_n[i], exp_err[i], exp_cyc[i]);
         end
      end
   endtask

   task automatic test_random;
      logic lvl;
      wave_in = 1'b0;
      apply_reset(2);
      drive(0, 3);
      lvl = 1'b1;
      for (int k = 0; k < 60; k++) begin
         drive(lvl, ($urandom_range(0, 7) == 0) ? int'($urandom_range(60, 70)) : int'($urandom_range(1, 40)));
         lvl = ~lvl;
      end
      drive(1, 4);
      #1;
      checks++;
      if (obs_m.size() !== exp_m.size()) begin
         failures++;
         $display("FAIL random_count: got %0d valid pulses, expected %0d", obs_m.size(), exp_m.size());
      end
      for (int i = 0; i < exp_m.size() && i < obs_m.size(); i++) begin
         checks++;
         if (obs_m[i] !== exp_m[i] || obs_n[i] !== exp_n[i] || obs_err[i] !== exp_err[i] || obs_stuck[i] !== 1'b0 || obs_cyc[i] !== exp_cyc[i]) begin
            failures++;
            $display("FAIL random_valid%0d: got m=%0d n=%0d err=%0d stuck=%0d cyc=%0d, expected m=%0d n=%0d err=%0d stuck=0 cyc=%0d",
                     i, obs_m[i], obs_n[i], obs_err[i], obs_stuck[i], obs_cyc[i], exp_m[i], exp_n[i], exp_err[i], exp_cyc[i]);
         end
      end
   endtask

   initial begin
      test_reset();
      test_periodic();
      test_floor_err();
      test_stuck();
      test_reset_high();
      test_reset_mid();
      test_random();
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end
endmodule
